// File: rtl/shift_amount_finder.sv
// shift_amount_finder
//   Sequential inverse of an 8-bit logical barrel shifter. It finds the
//   smallest amount k in 0..WIDTH-1 for which shifting data_in by k in
//   direction dir (zero fill) gives data_shifted. It tests one candidate
//   per clock.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request pulse, accepted only while busy=0
//   data_in      original (unshifted) word, sampled on the accept edge
//   data_shifted target (shifted) word, sampled on the accept edge
//   dir          0 = right shift, 1 = left shift, sampled on the accept edge
//   busy         search in progress
//   done         one-cycle pulse when found/shift_out are valid
//   found        1 = a matching shift amount exists
//   shift_out    smallest matching shift amount, 0 when found=0
//
// Handshake: start is a request that is consumed only on an edge where
// busy=0. Every accepted request produces exactly one done pulse.
// Requests seen while busy=1 are dropped, not queued.
module shift_amount_finder #(
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [WIDTH-1:0]           data_in,
    input  logic [WIDTH-1:0]           data_shifted,
    input  logic                       dir,
    output logic                       busy,
    output logic                       done,
    output logic                       found,
    output logic [$clog2(WIDTH)-1:0]   shift_out
);

    localparam int SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] target;
    logic             dir_q;
    logic [SW-1:0]    cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            target    <= '0;
            dir_q     <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            found     <= 1'b0;
            shift_out <= '0;
        end else begin
            // done is a single-cycle pulse; only the terminating edge raises it.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        work      <= data_in;
                        target    <= data_shifted;
                        dir_q     <= dir;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        found     <= 1'b0;
                        shift_out <= '0;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    // The equality test comes before the limit test, so a
                    // match at the last amount still reports found=1.
                    if (work == target) begin
                        found     <= 1'b1;
                        shift_out <= cnt;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        found     <= 1'b0;
                        shift_out <= '0;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        work <= dir_q ? (work << 1) : (work >> 1);
                        cnt  <= cnt + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_amount_finder.sv
// Testbench for shift_amount_finder. It applies directed and random searches
// and compares each one with a reference model that tries every shift amount
// directly.
module tb_shift_amount_finder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] data_in;
    logic [7:0] data_shifted;
    logic       dir;
    logic       busy;
    logic       done;
    logic       found;
    logic [2:0] shift_out;

    int vectors = 0;
    int miscompares = 0;

    shift_amount_finder #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .data_in      (data_in),
        .data_shifted (data_shifted),
        .dir          (dir),
        .busy         (busy),
        .done         (done),
        .found        (found),
        .shift_out    (shift_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: try each amount 0..7 and take the first one that matches.
    task automatic ref_find(input logic [7:0] d, input logic [7:0] t, input logic dr,
                            output logic f, output int s);
        logic [15:0] v;
        f = 1'b0;
        s = 0;
        for (int k = 0; k < 8; k++) begin
            v = dr ? ({8'h00, d} << k) : ({8'h00, d} >> k);
            if (!f && v[7:0] == t) begin
                f = 1'b1;
                s = k;
            end
        end
    endtask

    // Runs one search. When immediate=1 the request is driven in the current
    // cycle, which is used to start in the same cycle as a done pulse.
    task automatic run(input logic [7:0] d, input logic [7:0] t, input logic dr,
                       input bit immediate, input string tag);
        logic ef;
        int   es;
        int   exp_lat;
        int   lat;
        int   busy_n;
        bit   seen;
        bit   mid_bad;
        ref_find(d, t, dr, ef, es);
        exp_lat = ef ? es + 1 : 8;
        if (!immediate) @(negedge clk);
        data_in = d;
        data_shifted = t;
        dir = dr;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " busy_on_accept"}, busy, 1);
        lat = 0;
        busy_n = 1;
        seen = 0;
        mid_bad = 0;
        if (found !== 1'b0 || shift_out !== 3'd0 || done !== 1'b0) mid_bad = 1;
        while (!seen && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (done === 1'b1) seen = 1;
            else begin
                if (busy === 1'b1) busy_n++;
                if (found !== 1'b0 || shift_out !== 3'd0) mid_bad = 1;
            end
        end
        check({tag, " done_seen"}, seen, 1);
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " busy_cycles"}, busy_n, exp_lat);
        check({tag, " busy_at_done"}, busy, 0);
        check({tag, " clear_during_search"}, mid_bad, 0);
        check({tag, " found"}, found, ef);
        check({tag, " shift_out"}, shift_out, es);
    endtask

    initial begin
        logic [7:0] rd;
        logic [7:0] rt;
        logic       rdir;
        int         amt;
        int         pulses;
        logic       f_at;
        logic [2:0] s_at;

        rst_n = 1'b0;
        start = 1'b0;
        data_in = 8'h00;
        data_shifted = 8'h00;
        dir = 1'b0;
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset found", found, 0);
        check("reset shift_out", shift_out, 0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Directed searches
        run(8'hAA, 8'h15, 1'b0, 0, "right_aa_3");
        @(posedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("found_holds", found, 1);
        check("shift_holds", shift_out, 3);
        run(8'h0F, 8'h78, 1'b1, 0, "left_0f_3");
        run(8'hF0, 8'h3C, 1'b0, 1, "b2b_right_f0_2");
        run(8'h00, 8'h00, 1'b0, 0, "identity_00");
        run(8'h01, 8'h00, 1'b0, 0, "smallest_01");
        run(8'hAA, 8'hFF, 1'b0, 0, "nomatch_aa_ff");
        run(8'h80, 8'h00, 1'b0, 0, "nomatch_80_00");
        run(8'h80, 8'h01, 1'b0, 0, "last_amount_7");
        run(8'h01, 8'h80, 1'b1, 0, "left_last_7");

        // Re-pulsed start and changed inputs while busy
        @(negedge clk);
        data_in = 8'hAA;
        data_shifted = 8'h15;
        dir = 1'b0;
        start = 1'b1;
        @(negedge clk);
        data_in = 8'h00;
        data_shifted = 8'h00;
        dir = 1'b1;
        pulses = 0;
        f_at = 1'b0;
        s_at = 3'd0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) start = 1'b0;
            if (done === 1'b1) begin
                pulses++;
                f_at = found;
                s_at = shift_out;
            end
        end
        check("busy_restart pulses", pulses, 1);
        check("busy_restart found", f_at, 1);
        check("busy_restart shift_out", s_at, 3);

        // Asynchronous reset with a held result, then mid-search
        run(8'h0F, 8'h78, 1'b1, 0, "pre_reset");
        #2 rst_n = 1'b0;
        #1;
        check("areset_idle found", found, 0);
        check("areset_idle shift_out", shift_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        data_in = 8'hAA;
        data_shifted = 8'hFF;
        dir = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_mid busy", busy, 0);
        check("areset_mid done", done, 0);
        check("areset_mid found", found, 0);
        check("areset_mid shift_out", shift_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run(8'hF0, 8'h3C, 1'b0, 0, "after_reset");

        // Random searches, half built from a real shift so matches occur
        for (int n = 0; n < 40; n++) begin
            rd = 8'($urandom_range(0, 255));
            rdir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                amt = $urandom_range(0, 7);
                rt = rdir ? (rd << amt) : (rd >> amt);
            end else begin
                rt = 8'($urandom_range(0, 255));
            end
            run(rd, rt, rdir, n[0], "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
